// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_pkg: shared state encoding and latency limit for the stream reader
package mem_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int RD_LAT_MAX = 8;
endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: command, memory read and output stream signals of the reader
interface mem_stream_reader_if #(parameter int pW = 36, parameter int pA = 18);
    logic          istart;
    logic [pA-1:0] ibase;
    logic [pA-1:0] ilen;
    logic          obusy;
    logic          odone;
    logic          ordena;
    logic [pA-1:0] ord_adr;
    logic [pW-1:0] idat;
    logic          oval;
    logic [pW-1:0] odat;
    logic          iready;
    modport master (input istart, ibase, ilen, idat, iready, output obusy, odone, ordena, ord_adr, oval, odat);
    modport slave (output istart, ibase, ilen, idat, iready, input obusy, odone, ordena, ord_adr, oval, odat);
endinterface

// File: rtl/mem_stream_reader_fifo.sv
// stream_fifo: power-of-two circular buffer with occupancy count and clock enable
module stream_fifo #(
    parameter int pW     = 36,
    parameter int pDEPTH = 8
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     iclk_ena,
    input  logic                     iwrite,
    input  logic [pW-1:0]            iwdata,
    input  logic                     iread,
    output logic [pW-1:0]            ordata,
    output logic                     ofull,
    output logic                     oempty,
    output logic [$clog2(pDEPTH):0]  ocount
);
    localparam int AW = $clog2(pDEPTH);
    logic [pW-1:0] mem [pDEPTH];
    logic [AW-1:0] wp, rp;
    logic          wr, rd;
    assign wr     = iclk_ena && iwrite;
    assign rd     = iclk_ena && iread && !oempty;
    assign oempty = ocount == '0;
    assign ofull  = ocount == (AW+1)'(pDEPTH);
    assign ordata = mem[rp];
    always_ff @(posedge iclk)
        if (wr) mem[wp] <= iwdata;
    always_ff @(posedge iclk or posedge irst)
        if (irst) begin
            wp     <= '0;
            rp     <= '0;
            ocount <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            ocount <= ocount + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: issues credit-gated memory reads and streams the returned words out
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int pW     = 36,
    parameter int pA     = 18,
    parameter int pRD_LAT = 2,
    parameter int pDEPTH = 8
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                iclk_ena,
    mem_stream_reader_if.master bus
);
    localparam int LAT = pRD_LAT > RD_LAT_MAX ? RD_LAT_MAX : pRD_LAT;
    localparam int CW  = $clog2(pDEPTH) + 1;
    state_t          state, state_n;
    logic [pA-1:0]   adr, rem;
    logic [CW-1:0]   infl, fcount;
    logic [LAT-1:0]  vld;
    logic [pW-1:0]   head;
    logic            issue, push, pop, empty, full, done, done_n, drained;
    // credit covers reads still in the memory pipe plus words already buffered
    assign issue   = state == RUN && (infl + fcount) < CW'(pDEPTH);
    assign push    = vld[LAT-1];
    assign pop     = !empty && bus.iready && iclk_ena;
    assign drained = infl == '0 && fcount == CW'(pop);
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                state_n = bus.istart && bus.ilen != '0 ? RUN : IDLE;
                done_n  = bus.istart && bus.ilen == '0;
            end
            RUN:     state_n = issue && rem == pA'(1) ? DRAIN : RUN;
            DRAIN: begin
                state_n = drained ? IDLE : DRAIN;
                done_n  = drained;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge iclk or posedge irst)
        if (irst) begin
            state <= IDLE;
            done  <= 1'b0;
            adr   <= '0;
            rem   <= '0;
            infl  <= '0;
            vld   <= '0;
        end else if (iclk_ena) begin
            state <= state_n;
            done  <= done_n;
            infl  <= infl + CW'(issue) - CW'(push);
            vld   <= (vld << 1) | LAT'(issue);
            if (state == IDLE && bus.istart && bus.ilen != '0) begin
                adr <= bus.ibase;
                rem <= bus.ilen;
            end else if (issue) begin
                adr <= adr + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    stream_fifo #(.pW(pW), .pDEPTH(pDEPTH)) u_fifo (
        .iclk     (iclk),
        .irst     (irst),
        .iclk_ena (iclk_ena),
        .iwrite   (push && (!full || pop)),
        .iwdata   (bus.idat),
        .iread    (pop),
        .ordata   (head),
        .ofull    (full),
        .oempty   (empty),
        .ocount   (fcount)
    );
    assign bus.obusy   = state != IDLE;
    assign bus.odone   = done;
    assign bus.ordena  = issue;
    assign bus.ord_adr = adr;
    assign bus.oval    = !empty;
    assign bus.odat    = empty ? '0 : head;
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: randomized scoreboard bench with a latency-pipe memory model
module tb_mem_stream_reader;
    localparam int PW = 36, PA = 18, LAT = 2, DEPTH = 8;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    always #5 clk = ~clk;
    mem_stream_reader_if #(.pW(PW), .pA(PA)) bus ();
    mem_stream_reader #(.pW(PW), .pA(PA), .pRD_LAT(LAT), .pDEPTH(DEPTH)) dut (
        .iclk(clk), .irst(rst), .iclk_ena(ena), .bus(bus));
    int checks = 0, failures = 0;
    logic [PA-1:0] addr_q[$];
    logic [PW-1:0] exp_q[$];
    int done_q[$];
    logic [PW-1:0] salt = '0;
    int ready_mode = 0, ena_mode = 0, reads_issued = 0, ecnt = 0, last_x = 0, pulses = 0;
    logic last_en = 1'b0;
    typedef struct packed {logic v; logic [PA-1:0] a;} rd_t;
    rd_t pipe[LAT];
    function automatic logic [PW-1:0] mem_f(input logic [PA-1:0] a);
        return salt ^ PW'(a);
    endfunction
    function automatic logic [63:0] outs();
        return 64'({bus.obusy, bus.odone, bus.ordena, bus.oval, bus.ord_adr, bus.odat});
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    // memory: data returns LAT enabled cycles after the strobe; idle slots carry junk
    always @(posedge clk) if (ena) begin
        pipe[0] <= {bus.ordena, bus.ord_adr};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.idat = pipe[LAT-1].v ? mem_f(pipe[LAT-1].a) : {PW{1'b1}};
    always @(posedge clk) begin
        last_en <= ena;
        if (ena) ecnt <= ecnt + 1;
    end
    always @(posedge clk) begin
        #1;
        bus.iready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        ena = ena_mode == 0 ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    logic [63:0] snap;
    logic [PW-1:0] p_odat;
    logic snap_ok = 1'b0, p_oval = 1'b0, p_pop = 1'b0;
    always @(negedge clk) begin
        logic [PA-1:0] ea;
        logic [PW-1:0] ed;
        int l;
        if (rst) snap_ok = 1'b0;
        else begin
            if (snap_ok && !last_en) chk("hold_disabled", outs(), snap);
            if (snap_ok && p_oval && !p_pop && bus.oval) chk("stall_odat", 64'(bus.odat), 64'(p_odat));
            if (ena && bus.ordena) begin
                reads_issued++;
                chk("read_expected", 64'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) begin
                    ea = addr_q.pop_front();
                    chk("ord_adr", 64'(bus.ord_adr), 64'(ea));
                end
            end
            if (ena && bus.oval && bus.iready) begin
                chk("word_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ed = exp_q.pop_front();
                    chk("odat", 64'(bus.odat), 64'(ed));
                end
                last_x = ecnt + 1;
            end
            if (bus.odone && last_en) begin
                pulses++;
                chk("done_expected", 64'(done_q.size() != 0), 1);
                chk("done_obusy", 64'(bus.obusy), 0);
                chk("done_words_left", 64'(exp_q.size()), 0);
                if (done_q.size() != 0) begin
                    l = done_q.pop_front();
                    if (l != 0) chk("done_timing", 64'(ecnt), 64'(last_x));
                end
            end
            snap    = outs();
            p_odat  = bus.odat;
            p_oval  = bus.oval;
            p_pop   = bus.oval && bus.iready && ena;
            snap_ok = 1'b1;
        end
    end
    task automatic cmd(input logic [PA-1:0] b, input logic [PA-1:0] l);
        bus.ibase  = b;
        bus.ilen   = l;
        bus.istart = 1'b1;
        do @(posedge clk); while (!ena);
        for (int i = 0; i < int'(l); i++) begin
            addr_q.push_back(b + PA'(i));
            exp_q.push_back(mem_f(b + PA'(i)));
        end
        done_q.push_back(int'(l));
        #1 bus.istart = 1'b0;
    endtask
    task automatic busy_start(input logic [PA-1:0] b, input logic [PA-1:0] l);
        bus.ibase  = b;
        bus.ilen   = l;
        bus.istart = 1'b1;
        @(posedge clk);
        #1 bus.istart = 1'b0;
    endtask
    task automatic wait_done(input string name);
        int n = 0;
        while (done_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_complete"}, 64'(done_q.size()), 0);
        if (done_q.size() != 0) begin
            done_q.delete();
            addr_q.delete();
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask
    initial begin
        int n;
        bus.istart = 1'b0;
        bus.ibase  = '0;
        bus.ilen   = '0;
        repeat (3) @(posedge clk);
        #2 chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        cmd(18'h10, 4);
        n = 1;
        @(negedge clk);
        while (!bus.oval && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_oval_latency", 64'(n), 64'(LAT + 2));
        wait_done("basic");
        ready_mode = 2;
        @(posedge clk);
        #2;
        salt = PW'({$urandom, $urandom});
        reads_issued = 0;
        cmd(PA'($urandom), 20);
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_reads", 64'(reads_issued), 64'(DEPTH));
        chk("bp_ordena", 64'(bus.ordena), 0);
        chk("bp_oval", 64'(bus.oval), 1);
        ready_mode = 1;
        wait_done("backpressure");
        ready_mode = 0;
        cmd(18'h3FFFE, 4);
        wait_done("wrap");
        n = pulses;
        reads_issued = 0;
        cmd(18'h123, 0);
        repeat (3) @(negedge clk);
        chk("len0_pulses", 64'(pulses - n), 1);
        chk("len0_reads", 64'(reads_issued), 0);
        @(posedge clk);
        #2;
        ready_mode = 1;
        cmd(18'h100, 12);
        repeat (3) @(posedge clk);
        #2;
        busy_start(18'h2000, 5);
        repeat (4) @(posedge clk);
        #2;
        busy_start(18'h3000, 0);
        wait_done("busy_ignore");
        ready_mode = 2;
        @(posedge clk);
        #2;
        reads_issued = 0;
        cmd(PA'($urandom), 10);
        n = 0;
        while (reads_issued < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reads", 64'(reads_issued), 3);
        #2 rst = 1'b1;
        #1 chk("rst_mid_outputs", outs(), 0);
        addr_q.delete();
        exp_q.delete();
        done_q.delete();
        ready_mode = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        salt = PW'({$urandom, $urandom});
        cmd(PA'($urandom), 6);
        wait_done("post_reset");
        cmd(18'h2A0, 16);
        wait_done("ena_ref");
        ena_mode = 1;
        ready_mode = 1;
        cmd(18'h2A0, 16);
        wait_done("ena_toggle");
        for (int k = 0; k < 12; k++) begin
            ready_mode = $urandom_range(0, 1);
            ena_mode = $urandom_range(0, 1);
            salt = PW'({$urandom, $urandom});
            cmd(PA'($urandom), PA'($urandom_range(1, 24)));
            wait_done("random");
        end
        ena_mode = 0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        chk("addr_q_empty", 64'(addr_q.size()), 0);
        chk("exp_q_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter pW, default 36: data word width.
REQ-002 Parameter pA, default 18: memory address and length width.
REQ-003 Parameter pRD_LAT, default 2: fixed memory read latency, in enabled cycles, from ordena to valid idat; legal range 1..8.
REQ-004 Parameter pDEPTH, default 8: output FIFO depth; power of 2 and at least pRD_LAT+2.
REQ-005 iclk  in  1: single clock; all logic is rising-edge.
REQ-006 irst  in  1: reset, asynchronous, active-high.
REQ-007 iclk_ena  in  1: clock enable; when 0, all state and outputs hold.
REQ-008 istart  in  1: start-command strobe.
REQ-009 ibase  in  pA: start address, sampled with istart.
REQ-010 ilen  in  pA: word count, sampled with istart.
REQ-011 obusy  out  1: command in progress.
REQ-012 odone  out  1: single-cycle pulse at command completion.
REQ-013 ordena  out  1: memory read strobe.
REQ-014 ord_adr  out  pA: memory read address.
REQ-015 idat  in  pW: memory read data, valid pRD_LAT enabled cycles after ordena.
REQ-016 oval  out  1: output stream valid.
REQ-017 odat  out  pW: output stream data.
REQ-018 iready  in  1: output stream ready.

Function
REQ-019 The state machine SHALL have states IDLE, RUN and DRAIN; each "cycle" below means a cycle with iclk_ena=1.
REQ-020 In IDLE, istart with ilen!=0 SHALL latch ibase and ilen and enter RUN; obusy SHALL be 1 from the next cycle.
REQ-021 In IDLE, istart with ilen=0 SHALL pulse odone on the next cycle, stay in IDLE and issue no reads.
REQ-022 istart SHALL be ignored while obusy=1.
REQ-023 In RUN, ordena SHALL be 1 only when the credit test passes: in-flight reads plus FIFO occupancy is less than pDEPTH.
REQ-024 The first ord_adr SHALL equal ibase; each issued read SHALL increment the address by 1, wrapping modulo 2^pA (2^pA-1 is followed by 0).
REQ-025 After exactly ilen reads are issued, the block SHALL enter DRAIN.
REQ-026 A pRD_LAT-deep valid shift register SHALL track in-flight reads; idat SHALL be written to the FIFO when the delayed valid bit emerges.
REQ-027 The FIFO SHALL never overflow; credit gating guarantees it.
REQ-028 oval SHALL equal FIFO not-empty, and odat SHALL be the FIFO head.
REQ-029 A transfer SHALL occur when oval & iready & iclk_ena; odat SHALL stay stable while oval=1 and iready=0.
REQ-030 A simultaneous FIFO write and read SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-031 DRAIN SHALL go to IDLE when in-flight=0 and the FIFO is empty; odone SHALL pulse for one cycle and obusy SHALL fall in that same cycle.
REQ-032 With iready held at 1, throughput SHALL be 1 word per cycle, and the first oval SHALL appear pRD_LAT+2 cycles after istart.

Reset
REQ-033 Asserting irst SHALL immediately force: state IDLE; obusy, odone, ordena and oval to 0; ord_adr and odat to 0; FIFO pointers, counters and valid pipeline cleared.
REQ-034 Reset mid-command SHALL discard all in-flight and buffered data; idat returning after reset release SHALL be ignored.

Structure
REQ-035 Package mem_stream_pkg SHALL hold the state enum type (IDLE/RUN/DRAIN) and the constant for the pRD_LAT legal maximum.
REQ-036 The FIFO SHALL be the sub-module stream_fifo, parameterised by pW and pDEPTH, with iclk, irst, iclk_ena, write, read, full, empty and count ports.
REQ-037 The top level SHALL hold the FSM, the address and remaining counters, the credit counter and the latency pipeline.

Verification
REQ-038 Basic read: ibase=0x10, ilen=4, iready=1, memory returns data=address -> ord_adr 0x10..0x13 on consecutive cycles; odat 0x10..0x13; odone 1 cycle after the last transfer.
REQ-039 Backpressure: ilen=20, iready=0 -> exactly pDEPTH=8 reads issued, then ordena=0; raising iready -> all 20 words delivered in order with none lost.
REQ-040 Wrap-around: ibase=0x3FFFE, ilen=4 -> ord_adr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-041 Edge commands: ilen=0 -> odone pulses once with no ordena; istart during busy -> ignored, and the original command completes unchanged.
REQ-042 Reset mid-command: irst asserted after 3 of 10 reads -> outputs 0 immediately; a new command after release returns only the new data.
REQ-043 Clock enable: iclk_ena toggled randomly during ilen=16 -> output sequence identical to the iclk_ena=1 run, and all outputs hold in disabled cycles.
